// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Serial boot loader. Receives a program image over an 8N1 UART line and
// writes it word by word into program memory, holding the processor in reset
// until the whole image has arrived intact.
//
// Image format: 2-byte big-endian word count N, then N*4 data bytes with each
// word sent MSB byte first. Counts above MEMORY_DEPTH are rejected.
//
// Optional build macro LOADER_CHECKSUM_EN: when defined, one extra byte
// follows the data, equal to the XOR of all data bytes (length bytes
// excluded). It is also expected when N=0. A mismatch ends in ERROR.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (minimum 4)
//   MEMORY_DEPTH  program memory capacity in 32-bit words
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   rx_i         UART receive line (asynchronous, idles high)
//   prog_we_o    one-cycle write strobe to program memory
//   prog_addr_o  word-aligned byte address of the write (held between writes)
//   prog_data_o  instruction word to write (held between writes)
//   cpu_reset_o  high while the processor must stay in reset
//   done_o       image loaded successfully (sticky until reset)
//   error_o      load failed (sticky until reset)
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MEMORY_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_i,
    output logic        prog_we_o,
    output logic [31:0] prog_addr_o,
    output logic [31:0] prog_data_o,
    output logic        cpu_reset_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0]      MAX_WORDS = 17'(MEMORY_DEPTH);

    // ---------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizer; p2 is the previous synchronized
    // sample, used only for falling-edge detection.
    // ---------------------------------------------------------------------
    logic rx_p0, rx_p1, rx_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx_i;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    // ---------------------------------------------------------------------
    // UART receiver
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    logic             frame_err;
    logic [7:0]       rx_byte;

    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_p1 && rx_p2) rx_next = RX_START;
            // A start bit that reads high at its midpoint was a glitch.
            RX_START: if (bit_cnt == HALF_LAST) rx_next = rx_p1 ? RX_IDLE : RX_BITS;
            RX_BITS:  if (bit_cnt == BIT_LAST && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_cnt == BIT_LAST) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (rx_state == RX_STOP && bit_cnt == BIT_LAST) begin
            byte_valid = rx_p1;
            frame_err  = !rx_p1;
        end
    end

    assign rx_byte = rx_shift;

    // Bit timing counter and bit index; cleared whenever a sample is taken
    // so every later sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            bit_idx <= '0;
        end else begin
            case (rx_state)
                RX_START: begin
                    bit_idx <= '0;
                    if (bit_cnt == HALF_LAST) bit_cnt <= '0;
                    else                      bit_cnt <= bit_cnt + 1'b1;
                end
                RX_BITS, RX_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    // LSB arrives first, so shifting right leaves bit 0 in place after 8.
    always_ff @(posedge clk) begin
        if (rx_state == RX_BITS && bit_cnt == BIT_LAST)
            rx_shift <= {rx_p1, rx_shift[7:1]};
    end

    // ---------------------------------------------------------------------
    // Loader FSM
    // ---------------------------------------------------------------------
    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        DONE,
        ERROR
    } ld_state_t;

    ld_state_t   ld_state, ld_next;
    logic [7:0]  len_hi;
    logic [15:0] len_n;
    logic [15:0] word_count;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_sh;
    logic        last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk_acc;
`endif

    assign len_n = {len_hi, rx_byte};

    always_ff @(posedge clk) begin
        if (reset) ld_state <= LEN_HI;
        else       ld_state <= ld_next;
    end

    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            LEN_HI: begin
                if (frame_err)       ld_next = ERROR;
                else if (byte_valid) ld_next = LEN_LO;
            end
            LEN_LO: begin
                if (frame_err) begin
                    ld_next = ERROR;
                end else if (byte_valid) begin
                    if (len_n == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                        ld_next = CHK;
`else
                        ld_next = DONE;
`endif
                    else if ({1'b0, len_n} > MAX_WORDS)
                        ld_next = ERROR;
                    else
                        ld_next = DATA;
                end
            end
            DATA: begin
                // Leave only once the final word's strobe is on the bus.
                if (frame_err)                    ld_next = ERROR;
                else if (prog_we_o && last_word)
`ifdef LOADER_CHECKSUM_EN
                    ld_next = CHK;
`else
                    ld_next = DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (frame_err)       ld_next = ERROR;
                else if (byte_valid) ld_next = (rx_byte == chk_acc) ? DONE : ERROR;
            end
`endif
            DONE:    ld_next = DONE;
            ERROR:   ld_next = ERROR;
            default: ld_next = ERROR;
        endcase
    end

    always_comb begin
        cpu_reset_o = 1'b1;
        done_o      = 1'b0;
        error_o     = 1'b0;
        case (ld_state)
            DONE: begin
                cpu_reset_o = 1'b0;
                done_o      = 1'b1;
            end
            ERROR:   error_o = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Stage p3: write strobe, address and data registered one cycle after
    // the 4th byte of each word.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_we_o   <= 1'b0;
            prog_addr_o <= '0;
            prog_data_o <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            last_word   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc     <= '0;
`endif
        end else begin
            prog_we_o <= 1'b0;
            if (ld_state == DATA && byte_valid) begin
                byte_cnt <= byte_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                chk_acc  <= chk_acc ^ rx_byte;
`endif
                if (byte_cnt == 2'd3) begin
                    prog_we_o   <= 1'b1;
                    prog_data_o <= {word_sh, rx_byte};
                    prog_addr_o <= {14'd0, word_idx, 2'b00};
                    last_word   <= (word_idx == 16'(word_count - 16'd1));
                    word_idx    <= word_idx + 16'd1;
                end
            end
        end
    end

    // Datapath holding registers; only meaningful once loaded, so no reset.
    always_ff @(posedge clk) begin
        if (ld_state == LEN_HI && byte_valid) len_hi <= rx_byte;
        if (ld_state == LEN_LO && byte_valid) word_count <= len_n;
        if (ld_state == DATA && byte_valid && byte_cnt != 2'd3)
            word_sh <= {word_sh[15:0], rx_byte};
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int CPB   = 4;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_i = 1'b1;
    logic        prog_we_o;
    logic [31:0] prog_addr_o;
    logic [31:0] prog_data_o;
    logic        cpu_reset_o;
    logic        done_o;
    logic        error_o;

    program_loader #(
        .CLKS_PER_BIT(CPB),
        .MEMORY_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx_i),
        .prog_we_o   (prog_we_o),
        .prog_addr_o (prog_addr_o),
        .prog_data_o (prog_data_o),
        .cpu_reset_o (cpu_reset_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_we_cyc = -1;
    int          done_cyc = -1;
    bit          done_seen = 1'b0;
    logic [7:0]  chk = 8'h00;
    logic [63:0] exp_q[$];

    // One clock step; write strobes are popped against the scoreboard here.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (prog_we_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         prog_addr_o, prog_data_o);
            end else begin
                e = exp_q.pop_front();
                if ({prog_addr_o, prog_data_o} !== e) begin
                    n_err++;
                    $display("FAIL write_value: got addr=%h data=%h, required addr=%h data=%h",
                             prog_addr_o, prog_data_o, e[63:32], e[31:0]);
                end
            end
            last_we_cyc = cyc;
        end
        if (done_o === 1'b1 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_i  = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        exp_q.delete();
        done_seen   = 1'b0;
        done_cyc    = -1;
        last_we_cyc = -1;
        chk         = 8'h00;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) tick();
        end
        rx_i = stop_bit;
        repeat (CPB) tick();
        rx_i = 1'b1;
        repeat (2 * CPB) tick();
    endtask

    task automatic send_len(input logic [15:0] n);
        send_byte(n[15:8], 1'b1);
        send_byte(n[7:0], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx);
        logic [7:0] b;
        exp_q.push_back({32'(idx * 4), w});
        for (int k = 3; k >= 0; k--) begin
            b = w[k*8 +: 8];
            chk = chk ^ b;
            send_byte(b, 1'b1);
        end
    endtask

    task automatic send_chk();
`ifdef LOADER_CHECKSUM_EN
        send_byte(chk, 1'b1);
`endif
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && done_o !== 1'b1; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_i  = 1'b1;
        repeat (100) tick();
        n_cmp++; if (prog_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b, required 0", prog_we_o); end
        n_cmp++; if (prog_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h, required 0", prog_addr_o); end
        n_cmp++; if (prog_data_o !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h, required 0", prog_data_o); end
        n_cmp++; if (cpu_reset_o !== 1'b1) begin n_err++; $display("FAIL reset_cpu_reset: got %b, required 1", cpu_reset_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", done_o); end
        n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b, required 0", error_o); end
    endtask

    task automatic test_two_words();
        do_reset();
        send_len(16'd2);
        send_word(32'h20080005, 0);
        send_word(32'h01095020, 1);
        send_chk();
        wait_done();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL two_words_missing: got %0d pending, required 0", exp_q.size()); end
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL two_words_done: got %b, required 1", done_o); end
        n_cmp++; if (cpu_reset_o !== 1'b0) begin n_err++; $display("FAIL two_words_cpu_reset: got %b, required 0", cpu_reset_o); end
        n_cmp++; if (error_o !== 1'b0) begin n_err++; $display("FAIL two_words_error: got %b, required 0", error_o); end
        n_cmp++; if (prog_addr_o !== 32'h4 || prog_data_o !== 32'h01095020) begin
            n_err++; $display("FAIL two_words_hold: got addr=%h data=%h, required addr=4 data=01095020", prog_addr_o, prog_data_o);
        end
`ifndef LOADER_CHECKSUM_EN
        n_cmp++; if (done_cyc != last_we_cyc + 1) begin
            n_err++; $display("FAIL two_words_done_timing: got done at %0d, required %0d", done_cyc, last_we_cyc + 1);
        end
`endif
    endtask

    task automatic test_zero_len();
        do_reset();
        send_byte(8'h00, 1'b1);
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL zero_len_early_done: got %b, required 0", done_o); end
        send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL zero_len_done_before_chk: got %b, required 0", done_o); end
        send_chk();
`endif
        n_cmp++; if (done_o !== 1'b1 || cpu_reset_o !== 1'b0) begin
            n_err++; $display("FAIL zero_len_done: got done=%b cpu_reset=%b, required 1 0", done_o, cpu_reset_o);
        end
        for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b1);
        n_cmp++; if (done_o !== 1'b1 || error_o !== 1'b0) begin
            n_err++; $display("FAIL zero_len_ignore: got done=%b error=%b, required 1 0", done_o, error_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_len(16'd257);
        n_cmp++; if (error_o !== 1'b1 || cpu_reset_o !== 1'b1 || done_o !== 1'b0) begin
            n_err++; $display("FAIL overflow_state: got error=%b cpu_reset=%b done=%b, required 1 1 0", error_o, cpu_reset_o, done_o);
        end
        // A well-formed frame afterwards must be ignored; no writes expected.
        send_len(16'd1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h00, 1'b1);
        n_cmp++; if (error_o !== 1'b1 || done_o !== 1'b0 || cpu_reset_o !== 1'b1) begin
            n_err++; $display("FAIL overflow_sticky: got error=%b done=%b cpu_reset=%b, required 1 0 1", error_o, done_o, cpu_reset_o);
        end
    endtask

    task automatic test_frame_error();
        do_reset();
        send_len(16'd1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b0);
        n_cmp++; if (error_o !== 1'b1 || cpu_reset_o !== 1'b1 || done_o !== 1'b0) begin
            n_err++; $display("FAIL frame_error_state: got error=%b cpu_reset=%b done=%b, required 1 1 0", error_o, cpu_reset_o, done_o);
        end
        n_cmp++; if (prog_data_o !== 32'h0 || prog_addr_o !== 32'h0) begin
            n_err++; $display("FAIL frame_error_nowrite: got addr=%h data=%h, required 0 0", prog_addr_o, prog_data_o);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        rx_i = 1'b0;
        tick();
        rx_i = 1'b1;
        repeat (20) tick();
        n_cmp++; if (error_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++; $display("FAIL glitch_state: got error=%b done=%b, required 0 0", error_o, done_o);
        end
        send_len(16'd1);
        send_word(32'h12345678, 0);
        send_chk();
        wait_done();
        n_cmp++; if (exp_q.size() != 0 || done_o !== 1'b1) begin
            n_err++; $display("FAIL glitch_frame: got pending=%0d done=%b, required 0 1", exp_q.size(), done_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        do_reset();
        n_cmp++; if (cpu_reset_o !== 1'b1 || done_o !== 1'b0 || prog_data_o !== 32'h0) begin
            n_err++; $display("FAIL midreset_state: got cpu_reset=%b done=%b data=%h, required 1 0 0", cpu_reset_o, done_o, prog_data_o);
        end
        send_len(16'd1);
        send_word(32'hAABBCCDD, 0);
        send_chk();
        wait_done();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL midreset_missing: got %0d pending, required 0", exp_q.size()); end
        n_cmp++; if (done_o !== 1'b1 || error_o !== 1'b0) begin
            n_err++; $display("FAIL midreset_done: got done=%b error=%b, required 1 0", done_o, error_o);
        end
    endtask

    task automatic test_bad_checksum();
`ifdef LOADER_CHECKSUM_EN
        do_reset();
        send_len(16'd1);
        send_word(32'hAABBCCDD, 0);
        send_byte(chk ^ 8'h01, 1'b1);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL badchk_missing: got %0d pending, required 0", exp_q.size()); end
        n_cmp++; if (error_o !== 1'b1 || cpu_reset_o !== 1'b1 || done_o !== 1'b0) begin
            n_err++; $display("FAIL badchk_state: got error=%b cpu_reset=%b done=%b, required 1 1 0", error_o, cpu_reset_o, done_o);
        end
        n_cmp++; if (prog_data_o !== 32'hAABBCCDD) begin
            n_err++; $display("FAIL badchk_kept: got %h, required aabbccdd", prog_data_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_len();
        test_overflow();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_bad_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
